// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes,
// ALU operation codes and datapath mux select values.
package mc_ctrl_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp, funct3, op[5] and funct7b5.
// The illegal flag marks funct3 values this ALU cannot execute for R/I-type.
import mc_ctrl_pkg::*;

module alu_decoder (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
            default:                         illegal = 1'b1;
        endcase
    end

    // Only register-register ops with instr[30] set subtract; addi ignores it.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: sequences each instruction through its states and
// drives datapath selects, write enables and the ALU control code.
import mc_ctrl_pkg::*;

module mc_controller #(
    parameter bit EN_BNE  = 1'b1,
    parameter int STATE_W = MC_STATE_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr,
    output logic       InstrDone
);

    logic [STATE_W-1:0] state_q;
    state_t             state;
    state_t             next_state;
    logic [1:0]         alu_op;
    logic               pc_update;
    logic               branch;
    logic               taken;
    logic               funct_illegal;
    logic               branch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STATE_W'(S_RST);
        else        state_q <= STATE_W'(next_state);
    end

    assign state = state_t'(state_q[MC_STATE_W-1:0]);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl),
        .illegal     (funct_illegal)
    );

    assign branch_ok = (funct3 == F3_BEQ) || (EN_BNE && (funct3 == F3_BNE));
    assign taken     = (funct3 == F3_BNE) ? ~Zero : Zero;
    // Zero feeds PCWrite combinationally so the branch resolves in one cycle.
    assign PCWrite   = pc_update | (branch & taken);

    always_comb begin
        next_state   = S_FETCH;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_WD;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        InstrDone    = 1'b0;
        alu_op       = ALUOP_ADD;
        pc_update    = 1'b0;
        branch       = 1'b0;
        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R: begin
                        next_state   = funct_illegal ? S_FETCH : S_EXECUTER;
                        IllegalInstr = funct_illegal;
                    end
                    OP_I: begin
                        next_state   = funct_illegal ? S_FETCH : S_EXECUTEI;
                        IllegalInstr = funct_illegal;
                    end
                    OP_BR: begin
                        next_state   = branch_ok ? S_BRANCH : S_FETCH;
                        IllegalInstr = ~branch_ok;
                    end
                    OP_JAL:  next_state = S_JAL;
                    default: begin
                        next_state   = S_FETCH;
                        IllegalInstr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_WD;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_WD;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                InstrDone = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class state by
// state and compares the packed output vector against hand-written values.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic       IllegalInstr;
    logic       InstrDone;

    int assert_count = 0;
    int fail_count   = 0;

    // Packed as {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
    //            ALUSrcB, RegWrite, ALUControl, IllegalInstr, InstrDone}
    localparam logic [15:0] E_RST      = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [15:0] E_FETCH    = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [15:0] E_DECODE   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [15:0] E_DEC_ILL  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 3'b010, 1'b1, 1'b0};
    localparam logic [15:0] E_MEMADR   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMREAD  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMWB    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 1'b1};
    localparam logic [15:0] E_MEMWRITE = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b1};
    localparam logic [15:0] E_ALUWB    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 1'b1};
    localparam logic [15:0] E_JAL      = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 3'b010, 1'b0, 1'b0};

    mc_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .RegWrite     (RegWrite),
        .ALUControl   (ALUControl),
        .IllegalInstr (IllegalInstr),
        .InstrDone    (InstrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] e_exec_r(input logic [2:0] alu);
        return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, alu, 1'b0, 1'b0};
    endfunction

    function automatic logic [15:0] e_exec_i(input logic [2:0] alu);
        return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, alu, 1'b0, 1'b0};
    endfunction

    function automatic logic [15:0] e_branch(input logic pcw);
        return {pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'b110, 1'b0, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        logic [15:0] observed;
        observed = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, RegWrite, ALUControl, IllegalInstr, InstrDone};
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Starts in FETCH; runs an R/I-type op to completion and back to FETCH.
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [15:0] exp_exec);
        applyStimulus(o, f3, f7, 1'b1);
        tick(); checkOutput({tag, "_decode"}, E_DECODE);
        tick(); checkOutput({tag, "_exec"}, exp_exec);
        tick(); checkOutput({tag, "_aluwb"}, E_ALUWB);
        tick(); checkOutput({tag, "_fetch"}, E_FETCH);
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic pcw);
        applyStimulus(7'b1100011, f3, 1'b0, z);
        tick(); checkOutput({tag, "_decode"}, E_DECODE);
        tick(); checkOutput({tag, "_branch"}, e_branch(pcw));
        tick(); checkOutput({tag, "_fetch"}, E_FETCH);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_state", E_RST);
        rst_n = 1'b1;
        tick(); checkOutput("first_fetch", E_FETCH);

        run_alu("add",  7'b0110011, 3'b000, 1'b0, e_exec_r(3'b010));
        run_alu("sub",  7'b0110011, 3'b000, 1'b1, e_exec_r(3'b110));
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, e_exec_i(3'b010));
        run_alu("slti", 7'b0010011, 3'b010, 1'b0, e_exec_i(3'b111));
        run_alu("ori",  7'b0010011, 3'b110, 1'b0, e_exec_i(3'b001));
        run_alu("andi", 7'b0010011, 3'b111, 1'b0, e_exec_i(3'b000));
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, e_exec_r(3'b111));

        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
        tick(); checkOutput("lw_decode", E_DECODE);
        tick(); checkOutput("lw_memadr", E_MEMADR);
        tick(); checkOutput("lw_memread", E_MEMREAD);
        tick(); checkOutput("lw_memwb", E_MEMWB);
        tick(); checkOutput("lw_fetch", E_FETCH);

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        tick(); checkOutput("sw_decode", E_DECODE);
        tick(); checkOutput("sw_memadr", E_MEMADR);
        tick(); checkOutput("sw_memwrite", E_MEMWRITE);
        tick(); checkOutput("sw_fetch", E_FETCH);

        run_branch("beq_taken", 3'b000, 1'b1, 1'b1);
        run_branch("beq_not",   3'b000, 1'b0, 1'b0);
        run_branch("bne_taken", 3'b001, 1'b0, 1'b1);
        run_branch("bne_not",   3'b001, 1'b1, 1'b0);

        // Zero toggled mid-BRANCH must reach PCWrite without a clock edge.
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
        tick(); checkOutput("beqz_decode", E_DECODE);
        tick(); checkOutput("beqz_branch_z0", e_branch(1'b0));
        Zero = 1'b1;
        #1 checkOutput("beqz_branch_z1", e_branch(1'b1));
        tick(); checkOutput("beqz_fetch", E_FETCH);

        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
        tick(); checkOutput("jal_decode", E_DECODE);
        tick(); checkOutput("jal_jal", E_JAL);
        tick(); checkOutput("jal_aluwb", E_ALUWB);
        tick(); checkOutput("jal_fetch", E_FETCH);

        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
        tick(); checkOutput("illegal_op_decode", E_DEC_ILL);
        tick(); checkOutput("illegal_op_fetch", E_FETCH);

        applyStimulus(7'b0110011, 3'b001, 1'b0, 1'b0);
        tick(); checkOutput("illegal_rf3_decode", E_DEC_ILL);
        tick(); checkOutput("illegal_rf3_fetch", E_FETCH);

        applyStimulus(7'b1100011, 3'b100, 1'b0, 1'b1);
        tick(); checkOutput("illegal_bf3_decode", E_DEC_ILL);
        tick(); checkOutput("illegal_bf3_fetch", E_FETCH);

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        tick(); checkOutput("swrst_decode", E_DECODE);
        tick(); checkOutput("swrst_memadr", E_MEMADR);
        tick(); checkOutput("swrst_memwrite", E_MEMWRITE);
        #1 rst_n = 1'b0;
        #1 checkOutput("swrst_async", E_RST);
        tick(); checkOutput("swrst_held", E_RST);
        rst_n = 1'b1;
        tick(); checkOutput("swrst_fetch", E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control unit, directly upstream of the 32-bit ALU.
- Sequences each instruction through FETCH/DECODE/execute/writeback states.
- Drives datapath mux selects and write enables, and generates the 3-bit ALUControl the ALU consumes.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- EN_BNE, 1, when 1 funct3=001 under the branch opcode is bne (taken when Zero=0); when 0 it is illegal.
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (instr[6:0]), valid from DECODE onward
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag, combinational from the ALU
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- IllegalInstr  out  1  one-cycle pulse on an unsupported op/funct3 in DECODE
- InstrDone  out  1  one-cycle pulse in the final state of every instruction

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
- Reset: rst_n low forces state=RST asynchronously. In RST every output is 0 and ALUControl=010. RST->FETCH on the first clock after rst_n rises. Reset mid-instruction aborts it with no further writes.
- Outputs are Moore, decoded from state. PCWrite is the exception: PCWrite = PCUpdate | (Branch & taken), with Zero combinational into it. Every signal not listed for a state is 0.
- FETCH: IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- DECODE next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FETCH, with IllegalInstr=1 that cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Next is FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: RegWrite=1. Next is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1. Taken = Zero for funct3=000, ~Zero for funct3=001. Next is FETCH. Any other funct3 is trapped as illegal in DECODE.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate=1. Next is ALUWB.
- Latency in cycles, FETCH through last state inclusive:
  - lw 5
  - sw, R-type, I-type, jal 4
  - beq/bne 3
- InstrDone is asserted in MEMWB, MEMWRITE, ALUWB and BRANCH.
- ALU decode (combinational):
  - ALUOp 00 -> 010
  - ALUOp 01 -> 110
  - ALUOp 10, decoded by funct3:
    - 000 -> 110 if (op[5] & funct7b5), else 010
    - 010 -> 111
    - 110 -> 001
    - 111 -> 000
    - other -> 010, and DECODE flags IllegalInstr for R/I-type with that funct3
- op/funct inputs are sampled only from DECODE onward. The IR holds them stable because IRWrite=0 outside FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings, STATE_W wide
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL
  - ALUControl codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - ALUOp codes
  - ResultSrc, ALUSrcA and ALUSrcB select codes
- Sub-module alu_decoder: inputs ALUOp, funct3, op[5], funct7b5; outputs ALUControl and an illegal flag. It is purely combinational.
- mc_controller holds the state register, next-state logic and output decode.

Test Plan:
- Reset then add (op=0110011, f3=000, f7b5=0) -> RST, FETCH, DECODE, EXECUTER (ALUControl=010), ALUWB (RegWrite=1, InstrDone=1), FETCH; 4 cycles.
- sub (f7b5=1) then addi with instr[30]=1 (op=0010011) -> ALUControl=110 then 010; slti (f3=010) -> 111; ori -> 001; andi -> 000.
- lw (op=0000011) -> MEMADR (ALUSrcB=01), MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles. sw -> MEMWRITE with MemWrite=1 for exactly 1 cycle.
- beq with Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0. bne inverts both outcomes. Both take 3 cycles.
- op=1111111 -> IllegalInstr=1 in DECODE, next state FETCH, no RegWrite/MemWrite asserted.
- rst_n pulsed low during MEMWRITE -> MemWrite drops to 0 immediately (async); state RST, then FETCH after release.
